// File: rtl/ex_muldiv_unit_if.sv
// ex_muldiv_unit_if: EX-stage mul/div request, MTHI/MTLO and result bundle.
// master = pipeline side (start/op/a/b/flush/wr_*/wdata), slave = unit.
interface ex_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             stall_req;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush,
    output wr_hi, wr_lo, wdata,
    input  busy, done, stall_req, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    input  wr_hi, wr_lo, wdata,
    output busy, done, stall_req, hi, lo
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO, WIDTH+2 latency.
// Ports: clk, reset (async, high), bus (slave: request in, hi/lo/busy out).
module ex_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic clk,
  input logic reset,
  ex_muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic             neg_res;
  logic             neg_rem;
  logic             div_zero;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  // mult: {partial product, multiplier}
  // div: low half shifts dividend out, quotient in
  logic [2*WIDTH-1:0] acc;

  logic             sgn;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ok;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rmd;

  assign sgn   = bus.op[0];
  assign abs_a = (sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign abs_b = (sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
                 + (acc[0] ? {1'b0, opnd} : '0);

  // shifted partial remainder needs one extra bit
  assign div_shift = {rem, acc[WIDTH-1]};
  assign div_ok    = div_shift >= {1'b0, opnd};

  assign prod = neg_res ? -acc : acc;
  assign quo  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rmd  = neg_rem ? -rem : rem;

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.hi        = hi;
  assign bus.lo        = lo;
  assign bus.stall_req = busy | (bus.start & (state == IDLE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      a_q      <= '0;
      opnd     <= '0;
      rem      <= '0;
      acc      <= '0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            state    <= RUN;
            busy     <= 1'b1;
            cnt      <= '0;
            is_div   <= bus.op[1];
            neg_res  <= sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_rem  <= sgn & bus.a[WIDTH-1];
            div_zero <= bus.op[1] & (bus.b == '0);
            a_q      <= bus.a;
            rem      <= '0;
            opnd     <= bus.op[1] ? abs_b : abs_a;
            acc      <= {{WIDTH{1'b0}},
                         bus.op[1] ? abs_a : abs_b};
          end else if (!bus.start) begin
            if (bus.wr_hi) hi <= bus.wdata;
            if (bus.wr_lo) lo <= bus.wdata;
          end
        end
        RUN: begin
          if (bus.flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            if (is_div) begin
              acc[WIDTH-1:0] <= {acc[WIDTH-2:0], div_ok};
              rem <= div_ok
                ? WIDTH'(div_shift - {1'b0, opnd})
                : div_shift[WIDTH-1:0];
            end else begin
              acc <= {mul_sum, acc[WIDTH-1:1]};
            end
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!bus.flush) begin
            done <= 1'b1;
            if (!is_div) begin
              hi <= prod[2*WIDTH-1:WIDTH];
              lo <= prod[WIDTH-1:0];
            end else if (div_zero) begin
              hi <= a_q;
              lo <= '1;
            end else begin
              hi <= rmd;
              lo <= quo;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: random + directed checks of ex_muldiv_unit (W=32, W=8)
// against an arithmetic HI/LO model with a countdown timing model.
module tb_ex_muldiv_unit;

  localparam int W  = 32;
  localparam int W8 = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  ex_muldiv_unit_if #(.WIDTH(W))  bus ();
  ex_muldiv_unit_if #(.WIDTH(W8)) bus8 ();

  ex_muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  ex_muldiv_unit #(.WIDTH(W8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference result {hi, lo} for a w-bit op (w <= 32), plain arithmetic.
  function automatic logic [127:0] ref_op(input logic [1:0] op,
                                          input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int w);
    logic [63:0] mask;
    logic [63:0] up;
    longint sa, sb, q, r;
    logic [63:0] rh, rl;
    mask = (64'd1 << w) - 64'd1;
    sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
    rh = '0;
    rl = '0;
    case (op)
      2'b00: begin
        up = a * b;
        rh = (up >> w) & mask;
        rl = up & mask;
      end
      2'b01: begin
        up = sa * sb;
        rh = (up >> w) & mask;
        rl = up & mask;
      end
      default: begin
        if (b == 0) begin
          rl = mask;
          rh = a;
        end else if (op == 2'b10) begin
          rl = a / b;
          rh = a % b;
        end else begin
          q  = sa / sb;
          r  = sa % sb;
          rl = q & mask;
          rh = r & mask;
        end
      end
    endcase
    return {rh, rl};
  endfunction

  // Timing model for the 32-bit unit: countdown of remaining busy cycles.
  int           m_cnt  = 0;
  logic [31:0]  m_hi   = '0;
  logic [31:0]  m_lo   = '0;
  logic         m_done = 1'b0;
  logic [127:0] m_res  = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt  <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt > 0) begin
        if (bus.flush) begin
          m_cnt <= 0;
        end else if (m_cnt == 1) begin
          m_hi   <= m_res[95:64];
          m_lo   <= m_res[31:0];
          m_done <= 1'b1;
          m_cnt  <= 0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end else if (bus.start) begin
        if (!bus.flush) begin
          m_res <= ref_op(bus.op, 64'(bus.a), 64'(bus.b), W);
          m_cnt <= W + 1;
        end
      end else begin
        if (bus.wr_hi) m_hi <= bus.wdata;
        if (bus.wr_lo) m_lo <= bus.wdata;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 64'(bus.busy), 64'(m_cnt > 0));
    chk("done", 64'(bus.done), 64'(m_done));
    chk("hi", 64'(bus.hi), 64'(m_hi));
    chk("lo", 64'(bus.lo), 64'(m_lo));
    chk("stall_req", 64'(bus.stall_req),
        64'((m_cnt > 0) | (bus.start & (m_cnt == 0))));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] h,
                       output logic [31:0] l, output int lat);
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.wr_hi = 1'b0;
    bus.wr_lo = 1'b0;
    lat = 1;
    while (!bus.done && lat < W + 10) begin
      step();
      lat++;
    end
    if (!bus.done) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout32: got no done want done");
    end
    h = bus.hi;
    l = bus.lo;
  endtask

  task automatic do_op8(input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] b, output logic [7:0] h,
                        output logic [7:0] l, output int lat);
    bus8.op    = op;
    bus8.a     = a;
    bus8.b     = b;
    bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    lat = 1;
    while (!bus8.done && lat < W8 + 10) begin
      step();
      lat++;
    end
    if (!bus8.done) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout8: got no done want done");
    end
    h = bus8.hi;
    l = bus8.lo;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0]  h, l, v;
    logic [7:0]   h8, l8, a8, b8;
    logic [127:0] e;
    logic [1:0]   op;
    int lat, flush_at, saw;
    bit live;

    bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0; bus.flush = 0;
    bus.wr_hi = 0; bus.wr_lo = 0; bus.wdata = 0;
    bus8.start = 0; bus8.op = 0; bus8.a = 0; bus8.b = 0; bus8.flush = 0;
    bus8.wr_hi = 0; bus8.wr_lo = 0; bus8.wdata = 0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_hi", 64'(bus.hi), 64'h0);
    chk("rst_lo", 64'(bus.lo), 64'h0);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    chk("rst_done", 64'(bus.done), 64'h0);

    // pin the model itself on hand-computed values
    e = ref_op(2'b00, 64'd7, 64'd6, 32);
    chk("ref_multu", e[63:0], 64'h2A);
    e = ref_op(2'b01, 64'hFFFF_FFFD, 64'd5, 32);
    chk("ref_mult", {e[95:64], e[31:0]}, 64'hFFFF_FFFF_FFFF_FFF1);
    e = ref_op(2'b11, 64'hFFFF_FFF9, 64'd2, 32);
    chk("ref_div", {e[95:64], e[31:0]}, 64'hFFFF_FFFF_FFFF_FFFD);
    e = ref_op(2'b11, 64'h8000_0000, 64'hFFFF_FFFF, 32);
    chk("ref_minneg1", {e[95:64], e[31:0]}, 64'h0000_0000_8000_0000);

    do_op(2'b00, 32'd7, 32'd6, h, l, lat);
    chk("multu_lat", 64'(lat), 64'd34);
    chk("multu_7x6", {h, l}, 64'h0000_0000_0000_002A);
    do_op(2'b01, 32'hFFFF_FFFD, 32'd5, h, l, lat);
    chk("mult_neg3x5", {h, l}, 64'hFFFF_FFFF_FFFF_FFF1);
    chk("b2b_lat", 64'(lat), 64'd34);
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, h, l, lat);
    chk("multu_max", {h, l}, 64'hFFFF_FFFE_0000_0001);
    do_op(2'b11, 32'hFFFF_FFF9, 32'd2, h, l, lat);
    chk("div_neg7_2", {h, l}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, h, l, lat);
    chk("div_min_neg1", {h, l}, 64'h0000_0000_8000_0000);
    do_op(2'b10, 32'd100, 32'd0, h, l, lat);
    chk("divu_by0", {h, l}, 64'h0000_0064_FFFF_FFFF);
    chk("divu_by0_lat", 64'(lat), 64'd34);
    do_op(2'b11, 32'hFFFF_FF9C, 32'd0, h, l, lat);
    chk("div_by0", {h, l}, 64'hFFFF_FF9C_FFFF_FFFF);

    // flush mid-divide
    step();
    bus.wdata = 32'h11; bus.wr_hi = 1'b1; step();
    bus.wr_hi = 1'b0;
    bus.wdata = 32'h22; bus.wr_lo = 1'b1; step();
    bus.wr_lo = 1'b0;
    bus.op = 2'b10; bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (9) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("flush_busy", 64'(bus.busy), 64'h0);
    chk("flush_hilo", {bus.hi, bus.lo}, 64'h0000_0011_0000_0022);
    do_op(2'b10, 32'd100, 32'd7, h, l, lat);
    chk("after_flush", {h, l}, 64'h0000_0002_0000_000E);
    chk("after_flush_lat", 64'(lat), 64'd34);

    // start while busy is ignored
    bus.op = 2'b00; bus.a = 32'd3; bus.b = 32'd5; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (4) step();
    bus.op = 2'b10; bus.a = 32'd9; bus.b = 32'd1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < W + 10) begin
      step();
      lat++;
    end
    chk("busy_start", {bus.hi, bus.lo}, 64'h0000_0000_0000_000F);
    step();
    chk("busy_start_idle", 64'(bus.busy), 64'h0);

    // MTHI, then MTLO together with start
    bus.wdata = 32'hABCD; bus.wr_hi = 1'b1; step();
    bus.wr_hi = 1'b0;
    chk("mthi", 64'(bus.hi), 64'hABCD);
    bus.wdata = 32'hDEAD; bus.wr_lo = 1'b1;
    do_op(2'b00, 32'd2, 32'd3, h, l, lat);
    chk("mtlo_with_start", 64'(l), 64'd6);

    // async reset in cycle 20 of MULT
    bus.op = 2'b01; bus.a = 32'hFFFF_FFFD; bus.b = 32'd5; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (19) step();
    #2 reset = 1'b1;
    #1;
    chk("arst_hilo", {bus.hi, bus.lo}, 64'h0);
    chk("arst_busy", 64'(bus.busy), 64'h0);
    chk("arst_stall", 64'(bus.stall_req), 64'h0);
    @(posedge clk);
    #3 reset = 1'b0;
    saw = 0;
    repeat (W + 8) begin
      step();
      if (bus.done) saw = 1;
    end
    chk("arst_no_done", 64'(saw), 64'h0);

    // randomized traffic against the model
    for (int i = 0; i < 250; i++) begin
      bus.op    = 2'($urandom_range(0, 3));
      bus.a     = pick();
      bus.b     = ($urandom_range(0, 9) == 0) ? 32'h0 : pick();
      bus.flush = ($urandom_range(0, 15) == 0);
      bus.wdata = $urandom;
      bus.wr_hi = $urandom_range(0, 1);
      bus.wr_lo = $urandom_range(0, 1);
      live      = !bus.flush;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0; bus.flush = 1'b0;
      bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
      flush_at = ($urandom_range(0, 7) == 0) ? $urandom_range(1, W + 1) : 0;
      for (int c = 1; c <= W + 1; c++) begin
        bus.a = $urandom;
        bus.b = $urandom;
        if (c == flush_at) bus.flush = 1'b1;
        if (live && c <= W && $urandom_range(0, 9) == 0) bus.start = 1'b1;
        step();
        if (c == flush_at) live = 0;
        bus.flush = 1'b0;
        bus.start = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) begin
        v = $urandom;
        bus.wdata = v;
        bus.wr_hi = $urandom_range(0, 1);
        bus.wr_lo = !bus.wr_hi;
        step();
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
      end
    end
    repeat (3) step();

    // 8-bit build
    do_op8(2'b00, 8'd7, 8'd6, h8, l8, lat);
    chk("w8_multu", {h8, l8}, 64'h002A);
    chk("w8_lat", 64'(lat), 64'd10);
    do_op8(2'b00, 8'hFF, 8'hFF, h8, l8, lat);
    chk("w8_multu_max", {h8, l8}, 64'hFE01);
    do_op8(2'b11, 8'hF9, 8'd2, h8, l8, lat);
    chk("w8_div", {h8, l8}, 64'hFFFD);
    do_op8(2'b11, 8'h80, 8'hFF, h8, l8, lat);
    chk("w8_min_neg1", {h8, l8}, 64'h0080);
    do_op8(2'b10, 8'd100, 8'd0, h8, l8, lat);
    chk("w8_divu_by0", {h8, l8}, 64'h64FF);
    for (int i = 0; i < 40; i++) begin
      v  = pick();
      a8 = v[7:0];
      v  = pick();
      b8 = v[7:0];
      op = 2'($urandom_range(0, 3));
      e  = ref_op(op, 64'(a8), 64'(b8), W8);
      do_op8(op, a8, b8, h8, l8, lat);
      chk("w8_rand", {h8, l8}, {e[71:64], e[7:0]});
    end
    step();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Parametrised multi-cycle multiply/divide unit for the EX stage of the pipelined MIPS core. It adds MULT/MULTU/DIV/DIVU and the HI/LO register pair, with MTHI/MTLO writes. The unit runs an iterative shift-add multiplier or restoring divider for WIDTH cycles. While it runs, it raises a stall request so the hazard logic holds IF/ID/EX.

## Interface
Parameters:
- WIDTH, 32: operand width; even, ≥ 4.
- CNT_W, $clog2(WIDTH)+1: iteration counter width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; one clock domain.
- start  in  1  request operation; sampled only in IDLE.
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- a  in  WIDTH  multiplicand / dividend (forwarded rs).
- b  in  WIDTH  multiplier / divisor (forwarded rt).
- flush  in  1  abort the in-flight operation.
- wr_hi, wr_lo  in  1  MTHI/MTLO write enables.
- wdata  in  WIDTH  MTHI/MTLO data.
- busy  out  1  operation in flight (RUN or FIX).
- done  out  1  one-cycle pulse; HI/LO hold the new result.
- stall_req  out  1  combinational: busy | (start & state==IDLE).
- hi, lo  out  WIDTH  registered HI/LO.

## Operation
- State machine IDLE → RUN → FIX → IDLE.
- In IDLE with start=1, the unit latches op, a and b, and computes |a| and |b| for signed ops. It clears the counter and accumulator, then goes to RUN.
- RUN lasts exactly WIDTH cycles, one bit per cycle:
  - Multiply: shift-add over a 2·WIDTH-bit product.
  - Divide: restoring shift-subtract; partial remainder is WIDTH+1 bits.
- FIX lasts one cycle:
  - Signed multiply: negate the product if sign(a)≠sign(b).
  - Signed divide: negate the quotient if the signs differ; the remainder takes the sign of a.
  - At end of FIX, HI/LO are registered and the unit returns to IDLE.
- Result mapping:
  - Multiply: hi = product[2W-1:W], lo = product[W-1:0].
  - Divide: lo = quotient, hi = remainder.
- Divide by zero: detected at start, same latency. Result is lo = all ones and hi = a (unmodified), for both signed and unsigned.
- Signed MIN / −1: lo = MIN, hi = 0, as the natural wrap of the magnitude algorithm.
- wr_hi/wr_lo are honoured only in IDLE with start=0; ignored otherwise. wr_hi and wr_lo may be asserted together.
- start while busy is ignored; the pipeline must be stalled by stall_req anyway.
- flush in RUN or FIX: the unit goes to IDLE at the next edge. No done pulse, HI/LO unchanged, pending result discarded. flush in IDLE has no effect; flush together with start in IDLE means start is ignored.

## Timing
- Reset values (asynchronous): state IDLE, counter 0, hi 0, lo 0, busy 0, done 0. stall_req follows start.
- Start sampled at the end of cycle 0.
  - busy = 1 in cycles 1 to WIDTH+1 (RUN for 1..WIDTH, FIX for WIDTH+1).
  - done = 1 and new hi/lo visible in cycle WIDTH+2.
  - Start-to-done latency: WIDTH+2 cycles (34 for WIDTH=32).
- A new start is accepted in the done cycle; back-to-back issue period is WIDTH+2.
- done is registered, high for exactly one cycle, and never asserted after flush or reset.
- MTHI/MTLO write takes effect at the edge; the new value is visible the next cycle.
- Reset asserted mid-operation: all state clears immediately, independent of clk. No done pulse follows reset deassertion.
- hi/lo change only at end of FIX, on an MTHI/MTLO write, or on reset.

## Test plan
- WIDTH=32, MULTU a=7 b=6: busy in cycles 1–33, done in cycle 34; hi=0x00000000, lo=0x0000002A.
- MULT a=−3 (0xFFFFFFFD), b=5: hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU 0xFFFFFFFF×0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=−7, b=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - DIVU 100 / 0: lo=0xFFFFFFFF, hi=0x00000064.
- Flush in cycle 10 of DIVU 100/7 with prior hi=0x11, lo=0x22: busy=0 from cycle 11, no done, hi/lo remain 0x11/0x22. An immediate new start completes normally.
- Start asserted during busy: ignored, result of the first op only. wr_hi=1 with wdata=0xABCD in IDLE gives hi=0xABCD next cycle. wr_lo together with start in IDLE: write ignored.
- Reset pulse asynchronously (between edges) in cycle 20 of MULT: hi=lo=0, busy=0 and stall_req=0 immediately. No done afterwards; WIDTH=8 build also passes the MULTU and DIV cases scaled to 8 bits.
